// File: rtl/mul_share_arb.sv
// Round-robin front end that lets N_REQ requesters share one registered multiplier.
// Latency: operands accepted in cycle T produce rsp_valid/rsp_data in cycle T+MUL_LAT+1.
// Backpressure: req_ready is a combinational one-hot grant; responses cannot be stalled.
module mul_share_arb #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [WIDTH-1:0]       mul_p,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic             found;
  logic [PTR_W-1:0] win_idx;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [N_REQ-1:0] grant;
  logic             xfer;
  int               idx;

  // Tag pipeline mirrors the multiplier's latency: {valid, one-hot owner} per stage.
  logic [MUL_LAT-1:0] tag_vld;
  logic [N_REQ-1:0]   tag_id [MUL_LAT];

  // Search for the first valid requester starting at rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(idx);
        win_a   = req_a[idx*WIDTH +: WIDTH];
        win_b   = req_b[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Grant only when issue is enabled and not in reset; a grant is always a transfer.
  assign grant     = (found && en && !rst) ? (N_REQ'(1) << win_idx) : '0;
  assign xfer      = |grant;
  assign req_ready = grant;

  // Operands are zeroed on idle cycles so the multiplier sees no stale data.
  assign mul_a = xfer ? win_a : '0;
  assign mul_b = xfer ? win_b : '0;

  // Advance the round-robin pointer past the winner only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= PTR_W'((int'(win_idx) + 1) % N_REQ);
    end
  end

  // Shift issue tags alongside the operation travelling through the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= grant;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  // Capture the product when its tag leaves the pipe; data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (tag_vld[MUL_LAT-1]) begin
      rsp_valid <= tag_id[MUL_LAT-1];
      rsp_data  <= mul_p;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = (|tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT with MUL_LAT=1
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [7:0]  mul_a, mul_b, mul_p;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  // DUT with MUL_LAT=3
  logic        en3 = 1'b0;
  logic [3:0]  req_valid3 = '0;
  logic [3:0]  req_ready3;
  logic [31:0] req_a3 = '0;
  logic [31:0] req_b3 = '0;
  logic [7:0]  mul_a3, mul_b3, mul_p3;
  logic [3:0]  rsp_valid3;
  logic [7:0]  rsp_data3;
  logic        busy3;

  mul_share_arb #(.N_REQ(4), .WIDTH(8), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  mul_share_arb #(.N_REQ(4), .WIDTH(8), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3)
  );

  // Shared multiplier models: registered inputs, product after MUL_LAT cycles.
  logic [7:0] mp1;
  logic [7:0] mp3 [3];
  always @(posedge clk) mp1 <= 8'(mul_a * mul_b);
  always @(posedge clk) begin
    mp3[0] <= 8'(mul_a3 * mul_b3);
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign mul_p  = mp1;
  assign mul_p3 = mp3[2];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_valid3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    nxt();
    en = 1'b1;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    checks++;
    if (rsp_data !== 8'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d exp 0", rsp_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++;
    if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b exp 0", busy3); end
    req_valid = '0;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_single();
    nxt();
    req_valid = 4'b0010;
    req_a[15:8] = 8'd7;
    req_b[15:8] = 8'd9;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b exp 0010", req_ready); end
    checks++;
    if (mul_a !== 8'd7 || mul_b !== 8'd9) begin errors++; $display("FAIL single_operands: got %0d,%0d exp 7,9", mul_a, mul_b); end
    nxt();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_inflight: got rsp %b busy %b exp 0000 1", rsp_valid, busy); end
    nxt();
    #1;
    checks++;
    if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0010", rsp_valid); end
    checks++;
    if (rsp_data !== 8'd63) begin errors++; $display("FAIL single_rsp_data: got %0d exp 63", rsp_data); end
    checks++;
    if (dut1.rr_ptr !== 2'd2) begin errors++; $display("FAIL single_rr_ptr: got %0d exp 2", dut1.rr_ptr); end
    nxt();
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got rsp %b busy %b exp 0000 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    logic [7:0] exp_d;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd3;
    end
    for (int c = 0; c < 10; c++) begin
      nxt();
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_r = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      checks++;
      if (req_ready !== exp_r) begin errors++; $display("FAIL rr_grant c=%0d: got %b exp %b", c, req_ready, exp_r); end
      if (c < 8) begin
        checks++;
        if (mul_a !== 8'((c % 4) + 1)) begin errors++; $display("FAIL rr_mul_a c=%0d: got %0d exp %0d", c, mul_a, (c % 4) + 1); end
      end
      if (c >= 2) begin
        exp_r = 4'(1 << ((c - 2) % 4));
        exp_d = 8'(3 * (((c - 2) % 4) + 1));
        checks++;
        if (rsp_valid !== exp_r || rsp_data !== exp_d) begin
          errors++; $display("FAIL rr_rsp c=%0d: got %b/%0d exp %b/%0d", c, rsp_valid, rsp_data, exp_r, exp_d);
        end
      end else begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_early c=%0d: got %b exp 0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_truncation();
    nxt();
    req_valid = 4'b0001;
    req_a[7:0] = 8'd200;
    req_b[7:0] = 8'd3;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL trunc_ready0: got %b exp 0001", req_ready); end
    nxt();
    req_a[7:0] = 8'd255;
    req_b[7:0] = 8'd255;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || mul_a !== 8'd255) begin errors++; $display("FAIL trunc_ready1: got %b/%0d exp 0001/255", req_ready, mul_a); end
    nxt();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'd88) begin errors++; $display("FAIL trunc_600: got %b/%0d exp 0001/88", rsp_valid, rsp_data); end
    nxt();
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'd1) begin errors++; $display("FAIL trunc_65025: got %b/%0d exp 0001/1", rsp_valid, rsp_data); end
    nxt();
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 8'd1) begin errors++; $display("FAIL trunc_hold: got %b/%0d exp 0000/1", rsp_valid, rsp_data); end
  endtask

  task automatic test_enable_drain();
    req_a[7:0]   = 8'd5;
    req_b[7:0]   = 8'd6;
    req_a[23:16] = 8'd4;
    req_b[23:16] = 8'd11;
    nxt();
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL en_grant2: got %b exp 0100", req_ready); end
    nxt();
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_grant0: got %b exp 0001", req_ready); end
    nxt();
    en = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || mul_a !== 8'd0) begin errors++; $display("FAIL en_off_ready: got %b/%0d exp 0000/0", req_ready, mul_a); end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'd44) begin errors++; $display("FAIL en_drain_rsp2: got %b/%0d exp 0100/44", rsp_valid, rsp_data); end
    nxt();
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'd30 || busy !== 1'b1) begin
      errors++; $display("FAIL en_drain_rsp0: got %b/%0d busy %b exp 0001/30 busy 1", rsp_valid, rsp_data, busy);
    end
    checks++;
    if (dut1.rr_ptr !== 2'd1) begin errors++; $display("FAIL en_ptr_hold: got %0d exp 1", dut1.rr_ptr); end
    nxt();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL en_busy_fall: got busy %b rsp %b exp 0 0000", busy, rsp_valid); end
    nxt();
    en = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL en_resume: got %b exp 0100", req_ready); end
    nxt();
    req_valid = '0;
    repeat (3) nxt();
  endtask

  task automatic test_reset_midop();
    req_a[31:24] = 8'd3;
    req_b[31:24] = 8'd3;
    nxt();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL rstop_grant: got %b exp 1000", req_ready); end
    nxt();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstop_in_reset: got %b busy %b exp 0000 0", req_ready, busy); end
    nxt();
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstop_no_rsp c=%0d: got %b exp 0000", c, rsp_valid); end
      nxt();
    end
    checks++;
    if (dut1.rr_ptr !== 2'd0) begin errors++; $display("FAIL rstop_ptr: got %0d exp 0", dut1.rr_ptr); end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstop_first_grant: got %b exp 0010", req_ready); end
    nxt();
    req_valid = '0;
    repeat (3) nxt();
  endtask

  task automatic test_back_to_back_lat3();
    logic [7:0] exp_d;
    en3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      nxt();
      if (c < 4) begin
        req_valid3 = 4'b1000;
        req_a3[31:24] = 8'(2 * (c + 1));
        req_b3[31:24] = 8'(2 * c + 3);
      end else begin
        req_valid3 = '0;
      end
      #1;
      checks++;
      if (req_ready3 !== ((c < 4) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL lat3_grant c=%0d: got %b", c, req_ready3); end
      if (c >= 4 && c < 8) begin
        exp_d = 8'((2 * (c - 3)) * (2 * (c - 4) + 3));
        checks++;
        if (rsp_valid3 !== 4'b1000 || rsp_data3 !== exp_d) begin
          errors++; $display("FAIL lat3_rsp c=%0d: got %b/%0d exp 1000/%0d", c, rsp_valid3, rsp_data3, exp_d);
        end
      end else begin
        checks++;
        if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL lat3_no_rsp c=%0d: got %b exp 0000", c, rsp_valid3); end
      end
      if (c == 3) begin
        checks++;
        if (busy3 !== 1'b1) begin errors++; $display("FAIL lat3_busy: got %b exp 1", busy3); end
      end
      if (c == 8) begin
        checks++;
        if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_idle: got %b exp 0", busy3); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_enable_drain();
    test_reset_midop();
    test_back_to_back_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
